// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write arbiter.
// Optional burst lock is enabled with the FIFO_ARB_LOCK_EN macro.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WE   = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter must hold max(WE_CYC,GAP_CYC)-1; never narrower than 1 bit.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = max2(a, b);
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin priority encoder: first set req at or
// after ptr, wrapping. Reusable by any arbiter.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          valid
);

  logic [PW:0] w_j;

  // Walk from the far end so the candidate nearest ptr wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    w_j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = {1'b0, ptr} + (PW+1)'(k);
      if (w_j >= (PW+1)'(N)) w_j = w_j - (PW+1)'(N);
      if (req[w_j[PW-1:0]]) begin
        idx   = w_j[PW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write sequencer for an edge-synchronised byte FIFO.
// Define FIFO_ARB_LOCK_EN to let a locked winner keep priority.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WE_CYC  = 2,
  parameter int GAP_CYC = 3,
  parameter int AW      = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] dat,
  input  logic [NREQ-1:0]   lock,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        fifo_dati,
  output logic              fifo_we,
  input  logic              fifo_rd,
  output logic [AW:0]       level,
  output logic              fifo_full,
  output logic              underrun
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = cnt_w(WE_CYC, GAP_CYC);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_ptr;
  logic            r_we;
  logic [7:0]      r_dati;
  logic [NREQ-1:0] r_ack;
  logic [AW:0]     r_level;
  logic            r_under;

  logic [PW-1:0]   w_idx;
  logic            w_valid;
  logic            w_full;
  logic            w_grant;
  logic            w_we_done;
  logic            w_gap_done;
  logic            w_inc;
  logic            w_dec;
  logic [7:0]      w_byte;
  logic [PW-1:0]   w_nptr;
  logic [PW-1:0]   w_wrap;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .idx   (w_idx),
    .valid (w_valid)
  );

  assign w_full     = (r_level == DEPTH);
  assign w_grant    = (r_state == IDLE) && w_valid && !w_full;
  assign w_we_done  = (r_state == WE) &&
                      (r_cnt == CW'(WE_CYC - 1));
  assign w_gap_done = (r_state == GAP) &&
                      (r_cnt == CW'(GAP_CYC - 1));
  assign w_inc      = w_we_done;
  assign w_dec      = fifo_rd && (r_level != '0);

  always_comb begin
    w_byte = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == PW'(i)) w_byte = dat[8*i +: 8];
    end
  end

  assign w_wrap = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

`ifdef FIFO_ARB_LOCK_EN
  assign w_nptr = lock[w_idx] ? w_idx : w_wrap;
`else
  logic w_unused_lock;
  assign w_unused_lock = ^lock;
  assign w_nptr = w_wrap;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_grant)    w_next = WE;
      WE:      if (w_we_done)  w_next = GAP;
      GAP:     if (w_gap_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE || r_state != w_next)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_dati <= 8'h00;
      r_ack  <= '0;
      r_ptr  <= '0;
    end else begin
      r_ack <= '0;
      if (w_grant) begin
        r_we   <= 1'b1;
        r_dati <= w_byte;
        r_ack  <= NREQ'(1) << w_idx;
        r_ptr  <= w_nptr;
      end
      if (w_we_done) r_we <= 1'b0;
    end
  end

  // Simultaneous commit and read cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
      r_under <= 1'b0;
    end else begin
      if (w_inc && !w_dec)
        r_level <= r_level + 1'b1;
      else if (w_dec && !w_inc)
        r_level <= r_level - 1'b1;
      if (fifo_rd && r_level == '0) r_under <= 1'b1;
    end
  end

  assign ack       = r_ack;
  assign fifo_dati = r_dati;
  assign fifo_we   = r_we;
  assign level     = r_level;
  assign fifo_full = w_full;
  assign underrun  = r_under;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed scoreboard bench for fifo_wr_arb.
// Lock behaviour follows FIFO_ARB_LOCK_EN.
module tb_fifo_wr_arb;

  localparam int NREQ    = 4;
  localparam int WE_CYC  = 2;
  localparam int GAP_CYC = 3;
  localparam int AW      = 11;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] dat;
  logic [NREQ-1:0]   lock;
  logic [NREQ-1:0]   ack;
  logic [7:0]        fifo_dati;
  logic              fifo_we;
  logic              fifo_rd;
  logic [AW:0]       level;
  logic              fifo_full;
  logic              underrun;

  fifo_wr_arb #(
    .NREQ(NREQ), .WE_CYC(WE_CYC),
    .GAP_CYC(GAP_CYC), .AW(AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .dat       (dat),
    .lock      (lock),
    .ack       (ack),
    .fifo_dati (fifo_dati),
    .fifo_we   (fifo_we),
    .fifo_rd   (fifo_rd),
    .level     (level),
    .fifo_full (fifo_full),
    .underrun  (underrun)
  );

  typedef struct {
    int         idx;
    logic [7:0] b;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks    = 0;
  int   failures  = 0;
  int   ack_count = 0;
  int   cyc       = 0;
  int   we_len    = 0;
  bit   sb_on     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      we_len = 0;
    end else begin
      if (fifo_we) we_len++;
      else if (we_len != 0) begin
        chk("we_width", 32'(we_len), 32'(WE_CYC));
        we_len = 0;
      end
      if (|ack) begin
        ack_count++;
        if (sb_on) begin
          if (q.size() == 0) begin
            chk("unexpected_ack", 32'(ack), 32'd0);
          end else begin
            e = q.pop_front();
            chk("ack_lane", 32'(ack), 32'd1 << e.idx);
            chk("ack_byte", 32'(fifo_dati), 32'(e.b));
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input int lim);
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!(|ack) && n < lim);
    chk("ack_timeout", 32'(|ack), 32'd1);
  endtask

  task automatic push(input int idx, input logic [7:0] b);
    exp_t x;
    x.idx = idx;
    x.b   = b;
    q.push_back(x);
  endtask

  task automatic do_reset;
    rst_n   = 1'b0;
    req     = '0;
    lock    = '0;
    fifo_rd = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  int t1, t2, t3, a0, n;

  initial begin
    dat = '0;
    do_reset;
    chk("rst_we", 32'(fifo_we), 32'd0);
    chk("rst_dati", 32'(fifo_dati), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_under", 32'(underrun), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);

    // single requester, three bytes
    sb_on = 1;
    dat[7:0] = 8'h5A;
    push(0, 8'h5A); push(0, 8'h5A); push(0, 8'h5A);
    req = 4'b0001;
    wait_ack(10); t1 = cyc;
    wait_ack(10); t2 = cyc;
    wait_ack(10); t3 = cyc;
    req = '0;
    chk("period_1_2", 32'(t2 - t1), 32'd6);
    chk("period_2_3", 32'(t3 - t2), 32'd6);
    step(8);
    chk("single_level", 32'(level), 32'd3);
    chk("single_sb_empty", 32'(q.size()), 32'd0);

    // round robin over all four lanes
    do_reset;
    dat = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    push(0, 8'hA0); push(1, 8'hB1); push(2, 8'hC2);
    push(3, 8'hD3); push(0, 8'hA0);
    req = 4'b1111;
    repeat (5) wait_ack(10);
    req = '0;
    step(8);
    chk("rr_sb_empty", 32'(q.size()), 32'd0);
    chk("rr_level", 32'(level), 32'd5);

    // burst lock on lane 0
    do_reset;
    req  = 4'b0011;
    lock = 4'b0001;
`ifdef FIFO_ARB_LOCK_EN
    push(0, 8'hA0); push(0, 8'hA0);
    push(0, 8'hA0); push(0, 8'hA0);
    push(1, 8'hB1);
    repeat (4) wait_ack(10);
    req  = 4'b0010;
    lock = '0;
    wait_ack(10);
`else
    push(0, 8'hA0); push(1, 8'hB1);
    push(0, 8'hA0); push(1, 8'hB1);
    repeat (4) wait_ack(10);
`endif
    req  = '0;
    lock = '0;
    step(8);
    chk("lock_sb_empty", 32'(q.size()), 32'd0);
    sb_on = 0;

    // fill to full, then free one slot
    do_reset;
    ack_count = 0;
    dat[7:0] = 8'h11;
    req = 4'b0001;
    n = 0;
    while (!fifo_full && n < 13000) begin
      step(1);
      n++;
    end
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_level", 32'(level), 32'd2048);
    chk("fill_acks", 32'(ack_count), 32'd2048);
    a0 = ack_count;
    step(20);
    chk("full_blocks", 32'(ack_count), 32'(a0));
    fifo_rd = 1'b1;
    step(1);
    fifo_rd = 1'b0;
    chk("rd_level", 32'(level), 32'd2047);
    chk("rd_not_full", 32'(fifo_full), 32'd0);
    chk("rd_no_ack_yet", 32'(ack), 32'd0);
    step(1);
    chk("regrant", 32'(ack), 32'd1);
    req = '0;
    step(8);

    // read on the commit clock at level 5
    do_reset;
    req = 4'b0001;
    repeat (6) wait_ack(10);
    chk("pre_level5", 32'(level), 32'd5);
    req = '0;
    step(1);
    chk("we_high", 32'(fifo_we), 32'd1);
    fifo_rd = 1'b1;
    step(1);
    fifo_rd = 1'b0;
    chk("commit_we_low", 32'(fifo_we), 32'd0);
    chk("rd_commit_level", 32'(level), 32'd5);
    step(8);
    chk("rd_commit_hold", 32'(level), 32'd5);

    // underrun is sticky
    do_reset;
    chk("under_clear", 32'(underrun), 32'd0);
    fifo_rd = 1'b1;
    step(1);
    fifo_rd = 1'b0;
    chk("under_set", 32'(underrun), 32'd1);
    chk("under_level", 32'(level), 32'd0);
    step(10);
    chk("under_sticky", 32'(underrun), 32'd1);
    do_reset;
    chk("under_rst", 32'(underrun), 32'd0);

    // async reset during WE
    req = 4'b0001;
    wait_ack(10);
    chk("mid_we_high", 32'(fifo_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_we_drop", 32'(fifo_we), 32'd0);
    chk("mid_level", 32'(level), 32'd0);
    chk("mid_ack", 32'(ack), 32'd0);
    req = '0;
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("post_rst_we", 32'(fifo_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin arbiter and write sequencer that shares the write port of one byte FIFO (edge-synchronised `we`, no native full flag) among NREQ requesters, e.g. CPU register writes, MCU-status events and the mapper debug stream.
- Generates correctly shaped `we` pulses: high for WE_CYC clocks, then low for GAP_CYC clocks, so the FIFO's falling-edge detector commits exactly one byte per grant.
- Tracks occupancy by credit counting, using read pulses from the consumer side, and blocks grants when the FIFO is full.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WE_CYC, 2, clocks `fifo_we` is held high per byte (>=1)
- GAP_CYC, 3, clocks `fifo_we` is held low after each byte (>=2, so the 2-stage edge sync sees the low level)
- AW, 11, FIFO address width; depth = 2**AW

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- req, in, NREQ, per-requester write request (level)
- dat, in, 8*NREQ, per-requester byte; requester i uses bits [8i+7:8i], stable while req[i]=1
- lock, in, NREQ, per-requester burst lock (used only with FIFO_ARB_LOCK_EN)
- ack, out, NREQ, one-clock pulse: byte of requester i latched
- fifo_dati, out, 8, byte to FIFO
- fifo_we, out, 1, FIFO write strobe
- fifo_rd, in, 1, one-clock pulse per byte consumed from the FIFO
- level, out, AW+1, current occupancy 0..2**AW
- fifo_full, out, 1, level == 2**AW
- underrun, out, 1, sticky: fifo_rd was seen while level == 0

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, fifo_we=0, fifo_dati=8'h00, ack=0, level=0, underrun=0, rr_ptr=0.
- FSM states:
  - IDLE: if any req[i] and !fifo_full, pick the winner by round-robin starting at rr_ptr. Next clock: state=WE, fifo_dati=dat[winner], fifo_we=1, ack[winner]=1 for that single clock, rr_ptr=winner+1 mod NREQ.
  - WE: fifo_we=1 for exactly WE_CYC clocks, counting the entry clock. Then state=GAP and fifo_we=0. level increments on this WE->GAP transition.
  - GAP: fifo_we=0 for GAP_CYC clocks, then IDLE.
- Throughput: a held req gets one byte per WE_CYC+GAP_CYC+1 clocks at best (6 clocks at defaults).
- Ack latency: ack[i] occurs 1 clock after req[i] is sampled in IDLE. The requester must present its next byte, or drop req, on the clock after ack. req dropped before grant means no write and no ack.
- fifo_full blocks grants in IDLE only; a byte already in WE/GAP always completes.
- level arithmetic: +1 on WE->GAP, -1 on fifo_rd. Both in the same clock leaves level unchanged. fifo_rd at level 0 leaves level at 0 and sets underrun, which is cleared only by reset.
- Round-robin wrap: rr_ptr wraps NREQ-1 -> 0. A single continuous requester is granted every round.
- Reset mid-WE: fifo_we drops asynchronously. The FIFO may commit one partial byte, so the system resets the FIFO pointers together with rst_n.
- dat and req changes during WE/GAP are ignored; only the byte latched at grant is written.

Optional Feature:
- Macro: FIFO_ARB_LOCK_EN.
- Enabled: if the winner has lock[w]=1 at grant, rr_ptr stays at w, so w keeps priority on the next arbitration and multi-byte packets are not interleaved. The lock is released when the requester drops lock or req.
- Disabled: the lock input is ignored and pure round-robin applies.

Decomposition:
- Package fifo_arb_pkg: state enum {IDLE, WE, GAP}, and constant-width helpers for the counter width $clog2(max(WE_CYC,GAP_CYC)).
- Sub-module rr_pick: combinational round-robin priority encoder (req, ptr -> grant index, valid). It is reusable by other arbiters.

Test Plan:
- Single requester, dat=8'h5A, req held 3 grants: 3 ack pulses 6 clocks apart; fifo_we high 2 clocks each; level reaches 3.
- req=4'b1111, rr_ptr=0: grant order 0,1,2,3,0 with bytes matching each dat lane.
- Fill to 2048 with no fifo_rd: fifo_full=1 and no further ack. One fifo_rd pulse gives level=2047, and the next grant follows within 1 clock of IDLE.
- fifo_rd on the exact clock of WE->GAP at level=5: level stays 5.
- fifo_rd at level=0: underrun=1, level=0; underrun persists until rst_n.
- FIFO_ARB_LOCK_EN, req=4'b0011, lock[0]=1 for 4 bytes: ack[0] x4 consecutive, then ack[1].
- Separate directed case: rst_n low mid-WE makes fifo_we fall immediately and level=0.
